// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl
// Write-port controller for the register file. Round-robin arbitrates N_REQ
// writeback requesters onto the single write port and sequences every write
// as a SETUP cycle (address/data presented) followed by a STROBE cycle
// (writeEnable high), because the file latches on the rising edge of
// writeEnable. A busy-bit scoreboard tracks reserved destinations and flags
// read hazards for both read ports.
//
// Optional build macro: RFCTL_FWD_EN enables forwarding of the in-flight write
// data to the read ports (and suppresses the matching busy flag).
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   wr_req/wr_addr/wr_data per-requester write request, flattened addr/data
//   wr_gnt                 one-hot grant, high in the cycle of acceptance
//   resv_valid/resv_addr   destination reservation from the issue stage
//   resv_err               pulse: reservation of an already-busy register
//   readAddr0/readAddr1    register-file read addresses
//   rd0_busy/rd1_busy      combinational hazard flags for the read ports
//   writeEnable/writeAddr/dIn  register-file write port
//   fwd0_*/fwd1_*          forwarding outputs (zero unless RFCTL_FWD_EN)
//   dbg_state_o            current FSM state (0 IDLE, 1 SETUP, 2 STROBE)
//
// Handshake: a requester raises wr_req with stable wr_addr/wr_data and holds
// all three until it sees its wr_gnt bit high; the grant cycle is the cycle in
// which the request is consumed, and the requester may change or drop it from
// the next cycle on.
module rf_write_ctrl #(
   parameter int N     = 16,
   parameter int M     = 4,
   parameter int O     = 16,
   parameter int N_REQ = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   wr_req,
   input  logic [N_REQ*M-1:0] wr_addr,
   input  logic [N_REQ*N-1:0] wr_data,
   output logic [N_REQ-1:0]   wr_gnt,
   input  logic               resv_valid,
   input  logic [M-1:0]       resv_addr,
   output logic               resv_err,
   input  logic [M-1:0]       readAddr0,
   input  logic [M-1:0]       readAddr1,
   output logic               rd0_busy,
   output logic               rd1_busy,
   output logic               writeEnable,
   output logic [M-1:0]       writeAddr,
   output logic [N-1:0]       dIn,
   output logic               fwd0_valid,
   output logic               fwd1_valid,
   output logic [N-1:0]       fwd0_data,
   output logic [N-1:0]       fwd1_data,
   output logic [1:0]         dbg_state_o
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      STROBE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [M-1:0]    waddr_q, waddr_d;
   logic [N-1:0]    din_q, din_d;
   logic [O-1:0]    busy_q, busy_d;
   logic            resv_err_q, resv_err_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   cand_idx;
   logic            accept;

   // Round-robin search starting at the pointer.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_idx = PW'((int'(ptr_q) + k) % N_REQ);
         if (!win_found && wr_req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // New writes are only taken when the port is free (IDLE) or finishing its
   // strobe; rst gates the grant so nothing is handed out while held in reset.
   assign accept = win_found && !rst && (state_q == IDLE || state_q == STROBE);

   always_comb begin
      wr_gnt = '0;
      if (accept) wr_gnt[win_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      waddr_d = waddr_q;
      din_d   = din_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = STROBE;
         STROBE:  state_d = accept ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         waddr_d = wr_addr[int'(win_idx)*M +: M];
         din_d   = wr_data[int'(win_idx)*N +: N];
         ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
      end
   end

   // Scoreboard: the clear is applied first so a same-cycle reservation of the
   // register being written wins.
   always_comb begin
      busy_d     = busy_q;
      resv_err_d = 1'b0;
      if (state_q == STROBE) busy_d[waddr_q] = 1'b0;
      if (resv_valid) begin
         if (busy_q[resv_addr]) resv_err_d = 1'b1;
         else                   busy_d[resv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         waddr_q    <= '0;
         din_q      <= '0;
         busy_q     <= '0;
         resv_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         waddr_q    <= waddr_d;
         din_q      <= din_d;
         busy_q     <= busy_d;
         resv_err_q <= resv_err_d;
      end
   end

   // Decoded straight from the state register so reset drops it immediately.
   assign writeEnable = (state_q == STROBE);
   assign writeAddr   = waddr_q;
   assign dIn         = din_q;
   assign resv_err    = resv_err_q;
   assign dbg_state_o = state_q;

`ifdef RFCTL_FWD_EN
   logic wr_active;
   assign wr_active  = (state_q == SETUP) || (state_q == STROBE);
   assign fwd0_valid = wr_active && (readAddr0 == waddr_q);
   assign fwd1_valid = wr_active && (readAddr1 == waddr_q);
   assign fwd0_data  = fwd0_valid ? din_q : '0;
   assign fwd1_data  = fwd1_valid ? din_q : '0;
   // The in-flight value is available, so no hazard for a matching read.
   assign rd0_busy   = busy_q[readAddr0] && !fwd0_valid;
   assign rd1_busy   = busy_q[readAddr1] && !fwd1_valid;
`else
   assign fwd0_valid = 1'b0;
   assign fwd1_valid = 1'b0;
   assign fwd0_data  = '0;
   assign fwd1_data  = '0;
   assign rd0_busy   = busy_q[readAddr0];
   assign rd1_busy   = busy_q[readAddr1];
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
module tb_rf_write_ctrl;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int O  = 16;
  localparam int NR = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;

`ifdef RFCTL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   wr_req = '0;
  logic [NR*M-1:0] wr_addr = '0;
  logic [NR*N-1:0] wr_data = '0;
  logic [NR-1:0]   wr_gnt;
  logic            resv_valid = 1'b0;
  logic [M-1:0]    resv_addr = '0;
  logic            resv_err;
  logic [M-1:0]    readAddr0 = '0;
  logic [M-1:0]    readAddr1 = '0;
  logic            rd0_busy, rd1_busy;
  logic            writeEnable;
  logic [M-1:0]    writeAddr;
  logic [N-1:0]    dIn;
  logic            fwd0_valid, fwd1_valid;
  logic [N-1:0]    fwd0_data, fwd1_data;
  logic [1:0]      dbg_state;

  rf_write_ctrl #(.N(N), .M(M), .O(O), .N_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .resv_valid(resv_valid), .resv_addr(resv_addr), .resv_err(resv_err),
    .readAddr0(readAddr0), .readAddr1(readAddr1),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .dIn(dIn),
    .fwd0_valid(fwd0_valid), .fwd1_valid(fwd1_valid),
    .fwd0_data(fwd0_data), .fwd1_data(fwd1_data),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  // Entries are {addr, data} of each accepted write, popped when writeEnable rises.
  logic [M+N-1:0] exp_q[$];
  logic [M+N-1:0] sb_e;
  logic           we_prev = 1'b0;
  logic [M-1:0]   addr_prev = '0;
  logic [N-1:0]   din_prev = '0;

  always @(posedge clk) begin
    #2;
    if (writeEnable === 1'b1) begin
      checks++;
      if (we_prev !== 1'b0) begin
        errors++;
        $display("FAIL we_double: writeEnable=%0b previous=%0b, required previous=0", writeEnable, we_prev);
      end else begin
        checks++;
        if (writeAddr !== addr_prev || dIn !== din_prev) begin
          errors++;
          $display("FAIL we_stable: addr/data at rise %h/%h, previous cycle %h/%h", writeAddr, dIn, addr_prev, din_prev);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: write addr=%h data=%h with no expected entry", writeAddr, dIn);
        end else begin
          sb_e = exp_q.pop_front();
          if ({writeAddr, dIn} !== sb_e) begin
            errors++;
            $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h", writeAddr, dIn, sb_e[M+N-1:N], sb_e[N-1:0]);
          end
        end
      end
    end
    we_prev   = writeEnable;
    addr_prev = writeAddr;
    din_prev  = dIn;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [M-1:0] a, input logic [N-1:0] d);
    wr_addr[i*M +: M] = a;
    wr_data[i*N +: N] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wr_req = 3'b001;
    set_req(0, 4'h1, 16'h1111);
    step();
    checks++;
    if ({wr_gnt, writeEnable, writeAddr, dIn, resv_err, rd0_busy, rd1_busy,
         fwd0_valid, fwd1_valid, fwd0_data, fwd1_data, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b we=%b addr=%h din=%h err=%b busy=%b%b state=%0d, required all 0",
               wr_gnt, writeEnable, writeAddr, dIn, resv_err, rd0_busy, rd1_busy, dbg_state);
    end
    wr_req = '0;
    #1 rst = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || wr_gnt !== '0) begin
      errors++;
      $display("FAIL reset_release: state=%0d gnt=%b, required IDLE, 000", dbg_state, wr_gnt);
    end
  endtask

  task automatic test_single();
    set_req(1, 4'd3, 16'hBEEF);
    wr_req = 3'b010;
    #1;
    checks++;
    if (wr_gnt !== 3'b010) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b, required 010", wr_gnt);
    end
    exp_q.push_back({4'd3, 16'hBEEF});
    step();
    wr_req = '0;
    #1;
    checks++;
    if (writeEnable !== 1'b0 || writeAddr !== 4'd3 || dIn !== 16'hBEEF || dbg_state !== S_SETUP) begin
      errors++;
      $display("FAIL single_setup: we=%b addr=%h din=%h state=%0d, required 0/3/BEEF/SETUP", writeEnable, writeAddr, dIn, dbg_state);
    end
    step();
    checks++;
    if (writeEnable !== 1'b1 || dbg_state !== S_STROBE) begin
      errors++;
      $display("FAIL single_strobe: we=%b state=%0d, required 1/STROBE", writeEnable, dbg_state);
    end
    step();
    checks++;
    if (writeEnable !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL single_idle: we=%b state=%0d, required 0/IDLE", writeEnable, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    // Pulse reset so the round-robin pointer starts at 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < NR; i++)
      set_req(i, M'($urandom_range(0, 15)), N'($urandom_range(0, 16'hFFFF)));
    wr_req = 3'b111;
    #1;
    for (int g = 0; g < 6; g++) begin
      int w;
      w = g % 3;
      checks++;
      if (wr_gnt !== 3'(1 << w)) begin
        errors++;
        $display("FAIL rr_gnt: grant %0d gnt=%b, required %b", g, wr_gnt, 3'(1 << w));
      end
      exp_q.push_back({wr_addr[w*M +: M], wr_data[w*N +: N]});
      step();
      set_req(w, M'($urandom_range(0, 15)), N'($urandom_range(0, 16'hFFFF)));
      #1;
      checks++;
      if (wr_gnt !== '0 || writeEnable !== 1'b0) begin
        errors++;
        $display("FAIL rr_setup: grant %0d gnt=%b we=%b, required 000/0", g, wr_gnt, writeEnable);
      end
      step();
      if (g == 5) wr_req = '0;
      #1;
      checks++;
      if (writeEnable !== 1'b1) begin
        errors++;
        $display("FAIL rr_strobe: grant %0d we=%b, required 1", g, writeEnable);
      end
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: state=%0d we=%b, required IDLE/0", dbg_state, writeEnable);
    end
  endtask

  task automatic test_scoreboard();
    resv_valid = 1'b1;
    resv_addr  = 4'd5;
    readAddr0  = 4'd5;
    #1;
    checks++;
    if (rd0_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_pre_busy: rd0_busy=%b, required 0", rd0_busy);
    end
    step();
    resv_valid = 1'b0;
    #1;
    checks++;
    if (rd0_busy !== 1'b1 || resv_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_set: rd0_busy=%b resv_err=%b, required 1/0", rd0_busy, resv_err);
    end
    resv_valid = 1'b1;
    step();
    resv_valid = 1'b0;
    #1;
    checks++;
    if (resv_err !== 1'b1 || rd0_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_double_resv: resv_err=%b rd0_busy=%b, required 1/1", resv_err, rd0_busy);
    end
    step();
    checks++;
    if (resv_err !== 1'b0 || rd0_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_err_pulse: resv_err=%b rd0_busy=%b, required 0/1", resv_err, rd0_busy);
    end
    set_req(0, 4'd5, N'($urandom_range(0, 16'hFFFF)));
    wr_req = 3'b001;
    #1;
    checks++;
    if (wr_gnt !== 3'b001) begin
      errors++;
      $display("FAIL sb_wr_gnt: gnt=%b, required 001", wr_gnt);
    end
    exp_q.push_back({wr_addr[0 +: M], wr_data[0 +: N]});
    step();
    wr_req = '0;
    #1;
    checks++;
    if (rd0_busy !== !FWD) begin
      errors++;
      $display("FAIL sb_busy_setup: rd0_busy=%b, required %b", rd0_busy, !FWD);
    end
    step();
    checks++;
    if (rd0_busy !== !FWD || writeEnable !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_strobe: rd0_busy=%b we=%b, required %b/1", rd0_busy, writeEnable, !FWD);
    end
    step();
    checks++;
    if (rd0_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: rd0_busy=%b, required 0", rd0_busy);
    end
  endtask

  task automatic test_set_wins();
    set_req(1, 4'd7, N'($urandom_range(0, 16'hFFFF)));
    wr_req = 3'b010;
    #1;
    checks++;
    if (wr_gnt !== 3'b010) begin
      errors++;
      $display("FAIL sw_gnt: gnt=%b, required 010", wr_gnt);
    end
    exp_q.push_back({wr_addr[M +: M], wr_data[N +: N]});
    step();
    wr_req = '0;
    step();
    resv_valid = 1'b1;
    resv_addr  = 4'd7;
    readAddr1  = 4'd7;
    #1;
    checks++;
    if (writeEnable !== 1'b1 || writeAddr !== 4'd7) begin
      errors++;
      $display("FAIL sw_strobe: we=%b addr=%h, required 1/7", writeEnable, writeAddr);
    end
    step();
    resv_valid = 1'b0;
    #1;
    checks++;
    if (rd1_busy !== 1'b1 || resv_err !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL sw_set_wins: rd1_busy=%b resv_err=%b state=%0d, required 1/0/IDLE", rd1_busy, resv_err, dbg_state);
    end
  endtask

  task automatic test_reset_abort();
    resv_valid = 1'b1;
    resv_addr  = 4'd2;
    readAddr0  = 4'd2;
    set_req(2, 4'hA, N'($urandom_range(0, 16'hFFFF)));
    wr_req = 3'b100;
    #1;
    checks++;
    if (wr_gnt !== 3'b100) begin
      errors++;
      $display("FAIL ra_gnt: gnt=%b, required 100", wr_gnt);
    end
    exp_q.push_back({wr_addr[2*M +: M], wr_data[2*N +: N]});
    step();
    resv_valid = 1'b0;
    wr_req = '0;
    #1;
    checks++;
    if (rd0_busy !== 1'b1) begin
      errors++;
      $display("FAIL ra_busy: rd0_busy=%b, required 1", rd0_busy);
    end
    step();
    checks++;
    if (writeEnable !== 1'b1) begin
      errors++;
      $display("FAIL ra_strobe: we=%b, required 1", writeEnable);
    end
    #1;
    rst = 1'b1;
    set_req(2, 4'hC, 16'h5A5A);
    wr_req = 3'b100;
    #1;
    checks++;
    if (writeEnable !== 1'b0 || dbg_state !== S_IDLE || wr_gnt !== '0 || rd0_busy !== 1'b0 || rd1_busy !== 1'b0) begin
      errors++;
      $display("FAIL ra_async: we=%b state=%0d gnt=%b busy=%b%b, required 0/IDLE/000/00",
               writeEnable, dbg_state, wr_gnt, rd0_busy, rd1_busy);
    end
    step();
    checks++;
    if (wr_gnt !== '0 || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL ra_held: gnt=%b we=%b during reset, required 000/0", wr_gnt, writeEnable);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (wr_gnt !== 3'b100) begin
      errors++;
      $display("FAIL ra_regrant: gnt=%b, required 100", wr_gnt);
    end
    exp_q.push_back({4'hC, 16'h5A5A});
    step();
    wr_req = '0;
    #1;
    checks++;
    if (dbg_state !== S_SETUP || writeAddr !== 4'hC || dIn !== 16'h5A5A) begin
      errors++;
      $display("FAIL ra_setup: state=%0d addr=%h din=%h, required SETUP/C/5A5A", dbg_state, writeAddr, dIn);
    end
    step();
    step();
  endtask

  task automatic test_fwd();
    resv_valid = 1'b1;
    resv_addr  = 4'd9;
    readAddr1  = 4'd9;
    step();
    resv_valid = 1'b0;
    set_req(0, 4'd9, 16'h1234);
    wr_req = 3'b001;
    #1;
    checks++;
    if (wr_gnt !== 3'b001 || rd1_busy !== 1'b1 || fwd1_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_idle: gnt=%b rd1_busy=%b fwd1_valid=%b, required 001/1/0", wr_gnt, rd1_busy, fwd1_valid);
    end
    exp_q.push_back({4'd9, 16'h1234});
    step();
    wr_req = '0;
    #1;
    checks++;
    if (fwd1_valid !== FWD || fwd1_data !== (FWD ? 16'h1234 : 16'h0000) || rd1_busy !== !FWD) begin
      errors++;
      $display("FAIL fwd_setup: fwd1_valid=%b fwd1_data=%h rd1_busy=%b, required %b/%h/%b",
               fwd1_valid, fwd1_data, rd1_busy, FWD, (FWD ? 16'h1234 : 16'h0000), !FWD);
    end
    step();
    checks++;
    if (fwd1_valid !== FWD || rd1_busy !== !FWD || fwd0_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_strobe: fwd1_valid=%b rd1_busy=%b fwd0_valid=%b, required %b/%b/0",
               fwd1_valid, rd1_busy, fwd0_valid, FWD, !FWD);
    end
    step();
    checks++;
    if (fwd1_valid !== 1'b0 || rd1_busy !== 1'b0) begin
      errors++;
      $display("FAIL fwd_done: fwd1_valid=%b rd1_busy=%b, required 0/0", fwd1_valid, rd1_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_scoreboard();
    test_set_wins();
    test_reset_abort();
    test_fwd();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
